// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_pkg
//  Description : Shared definitions for the paper-tape reader path: 5-bit
//                character codes used by the host/I-O interface and the
//                reader handshake state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    // 5-bit character codes
    localparam logic [4:0] c_code_blank       = 5'b00000;
    localparam logic [4:0] c_code_write       = 5'b00110;
    localparam logic [4:0] c_code_end         = 5'b00111;
    localparam logic [4:0] c_code_select      = 5'b00001;
    localparam logic [4:0] c_code_number_mask = 5'b10000;

    // Reader handshake state encoding
    localparam int         c_state_w    = 2;
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_present = 2'd1;
    localparam logic [1:0] c_st_gap     = 2'd2;

    function automatic logic is_blank(input logic [4:0] code);
        return (code == c_code_blank);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reader_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : reader_fifo
//  Description : Character FIFO for the tape reader. Power-of-two depth,
//                pointers wrap naturally, synchronous clear dominates
//                push/pop. Push at full and pop at empty are ignored.
//  Ports       : clk, resetn       - clock, async active-low reset
//                i_push/i_wr_data  - write strobe and 5-bit character
//                i_pop             - drop head entry
//                i_clear           - flush (empty, pointers to 0)
//                o_rd_data         - head entry (valid when !o_empty)
//                o_full/o_empty    - occupancy flags
//                o_count           - occupancy 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module reader_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic [4:0]               i_wr_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [4:0]               o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                    c_addr_w  = $clog2(DEPTH);
    localparam logic [c_addr_w-1:0]   c_ptr_one = c_addr_w'(1);
    localparam logic [c_addr_w:0]     c_cnt_one = (c_addr_w + 1)'(1);
    localparam logic [c_addr_w:0]     c_cnt_max = (c_addr_w + 1)'(DEPTH);

    logic [4:0]          r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_cnt_max);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop  & ~o_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through o_rd_data
    // once the count says an entry has been written.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tape_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tape_reader
//  Description : Buffers 5-bit characters from the host and offers them one
//                at a time to the I/O unit with a val/rdy handshake, keeping
//                a minimum idle gap between characters.
//  Ports       : clk, resetn                    - clock, async active-low reset
//                host_val/data_from_host        - host character in
//                host_rdy_to_host               - FIFO can take a character
//                input_rdy_from_io              - I/O unit ready
//                input_val/data_to_io           - character to I/O unit
//                skip_blank_from_pnl            - discard blank code on entry
//                clear_from_pnl                 - flush reader
//                reader_busy_to_pnl             - work pending
//                fill_level_to_pnl              - FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module tape_reader
    import io_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int CHAR_GAP = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       host_val_from_host,
    input  logic [4:0] host_data_from_host,
    output logic       host_rdy_to_host,
    input  logic       input_rdy_from_io,
    output logic       input_val_to_io,
    output logic [4:0] input_data_to_io,
    input  logic       skip_blank_from_pnl,
    input  logic       clear_from_pnl,
    output logic       reader_busy_to_pnl,
    output logic [4:0] fill_level_to_pnl
);

    localparam logic [7:0] c_gap_load = 8'(CHAR_GAP - 1);

    logic [c_state_w-1:0]  r_state;
    logic [c_state_w-1:0]  w_state_next;
    logic [7:0]            r_gap_cnt;
    logic [4:0]            r_data;

    logic                  w_host_rdy;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load_data;
    logic                  w_val;
    logic [4:0]            w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [$clog2(DEPTH):0] w_count;

    // A blank with skip enabled completes the host handshake but is not
    // written into the FIFO.
    assign w_host_rdy = ~w_full & ~clear_from_pnl;
    assign w_push     = host_val_from_host & w_host_rdy &
                        ~(skip_blank_from_pnl & is_blank(host_data_from_host));

    reader_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .i_push    (w_push),
        .i_wr_data (host_data_from_host),
        .i_pop     (w_pop),
        .i_clear   (clear_from_pnl),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_st_idle;
        end else if (clear_from_pnl) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (!w_empty && input_rdy_from_io) w_state_next = c_st_present;
            end
            c_st_present: begin
                if (!input_rdy_from_io) w_state_next = c_st_gap;
            end
            c_st_gap: begin
                if (r_gap_cnt == 8'd0) w_state_next = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_val       = 1'b0;
        w_pop       = 1'b0;
        w_load_data = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_load_data = ~w_empty & input_rdy_from_io & ~clear_from_pnl;
            end
            c_st_present: begin
                w_val = 1'b1;
                // The character leaves the FIFO when the I/O unit signals it
                // has taken it by dropping rdy.
                w_pop = ~input_rdy_from_io & ~clear_from_pnl;
            end
            default: begin
                w_val = 1'b0;
            end
        endcase
    end

    // Gap counter: loaded on the pop, counts down while in the gap state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_gap_cnt <= 8'd0;
        end else if (clear_from_pnl) begin
            r_gap_cnt <= 8'd0;
        end else if (w_pop) begin
            r_gap_cnt <= c_gap_load;
        end else if (r_state == c_st_gap && r_gap_cnt != 8'd0) begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
        end
    end

    // Output data register holds its last value outside the present state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data <= 5'b00000;
        end else if (w_load_data) begin
            r_data <= w_head;
        end
    end

    assign host_rdy_to_host   = w_host_rdy;
    assign input_val_to_io    = w_val;
    assign input_data_to_io   = r_data;
    assign reader_busy_to_pnl = ~w_empty | (r_state != c_st_idle);
    assign fill_level_to_pnl  = 5'(w_count);

endmodule
`default_nettype wire
